// File: rtl/mac_pkg.sv
// Shared MAC datapath definitions: adder width and the word type used on adder operands/results.
package mac_pkg;

  localparam int unsigned ADD_W = 8;

  typedef logic [ADD_W-1:0] add_word_t;

endpackage

// File: rtl/full_adder.sv
// 1-bit combinational full adder; one stage of the adder_8bit ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder with combinational sum/carry/overflow and a registered copy for
// pipelined MAC use.
module adder_8bit
  import mac_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  add_word_t A,
  input  add_word_t B,
  input  logic      Cin,
  output add_word_t S,
  output logic      Cout,
  output logic      V,
  output add_word_t S_q,
  output logic      Cout_q,
  output logic      V_q
);

  logic [ADD_W:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < ADD_W; i++) begin : g_stage
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

  assign Cout = c[ADD_W];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign V    = c[ADD_W-1] ^ c[ADD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q    <= '0;
      Cout_q <= 1'b0;
      V_q    <= 1'b0;
    end else begin
      S_q    <= S;
      Cout_q <= Cout;
      V_q    <= V;
    end
  end

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: directed table, exhaustive sweep, register/reset sequences
// and randomized traffic against an arithmetic reference model.
module tb_adder_8bit;
  import mac_pkg::*;

  logic      clk;
  logic      rst;
  logic      clk_en;
  add_word_t A;
  add_word_t B;
  logic      Cin;
  add_word_t S;
  logic      Cout;
  logic      V;
  add_word_t S_q;
  logic      Cout_q;
  logic      V_q;

  int total;
  int bad;

  adder_8bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .S      (S),
    .Cout   (Cout),
    .V      (V),
    .S_q    (S_q),
    .Cout_q (Cout_q),
    .V_q    (V_q)
  );

  // Clock stays idle until the combinational-only tests are done.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       v;
  } vec_t;

  // Reference: {V, Cout, S} from plain 9-bit arithmetic and the sign-bit overflow rule.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin);
    logic [8:0] sum;
    logic       v;
    sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    v   = (a[7] == b[7]) && (sum[7] != a[7]);
    return {v, sum};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin);
    A   = a;
    B   = b;
    Cin = cin;
  endtask

  initial begin
    vec_t       vecs[8];
    logic [9:0] exp;
    logic [9:0] prev;

    total  = 0;
    bad    = 0;
    clk_en = 1'b0;
    drive(8'h00, 8'h00, 1'b0);

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

    // Reset state with no clock.
    rst = 1'b1;
    #2;
    check("reset S_q", S_q, 0);
    check("reset Cout_q", Cout_q, 0);
    check("reset V_q", V_q, 0);
    rst = 1'b0;

    // Directed table, clock idle.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      #10;
      check($sformatf("vec%0d S", i), S, vecs[i].s);
      check($sformatf("vec%0d Cout", i), Cout, vecs[i].cout);
      check($sformatf("vec%0d V", i), V, vecs[i].v);
    end
    check("regs idle without clock", {V_q, Cout_q, S_q}, 0);

    // Exhaustive sweep of all A, B, Cin.
    for (int i = 0; i < (1 << 17); i++) begin
      logic [16:0] k;
      k = i[16:0];
      drive(k[7:0], k[15:8], k[16]);
      #1;
      check($sformatf("exh a=%0h b=%0h c=%0b", k[7:0], k[15:8], k[16]), {V, Cout, S},
            ref_add(k[7:0], k[15:8], k[16]));
    end

    // Register latency.
    clk_en = 1'b1;
    drive(8'h00, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8'h12, 8'h34, 1'b1);
    #1;
    check("S_q before edge", S_q, 8'h00);
    check("S comb 0x47", S, 8'h47);
    @(posedge clk);
    #1;
    check("S_q after edge", S_q, 8'h47);
    check("Cout_q after edge", Cout_q, 0);
    check("V_q after edge", V_q, 0);

    // Async reset between edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async rst S_q", S_q, 0);
    check("async rst Cout_q", Cout_q, 0);
    check("async rst V_q", V_q, 0);
    check("S during rst", S, 8'h47);
    @(posedge clk);
    #1;
    check("S_q held in rst", S_q, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("S_q after release pre-edge", S_q, 0);
    @(posedge clk);
    #1;
    check("S_q reload", S_q, 8'h47);

    // Overflow/carry through the register.
    @(negedge clk);
    drive(8'h80, 8'h80, 1'b0);
    @(posedge clk);
    #1;
    check("reg 80+80", {V_q, Cout_q, S_q}, {1'b1, 1'b1, 8'h00});

    // Randomized traffic.
    prev = ref_add(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      drive(ra, rb, rc);
      exp = ref_add(ra, rb, rc);
      #1;
      check("rand comb", {V, Cout, S}, exp);
      check("rand reg pre-edge", {V_q, Cout_q, S_q}, prev);
      @(posedge clk);
      #1;
      check("rand reg", {V_q, Cout_q, S_q}, exp);
      prev = exp;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
